spi_flash_sequencer: RTL and testbench

Sequencer and arbiter in front of the byte-wide SPI master engine. Turns a 24-bit word-fetch request into a complete SPI read transaction: chip-select assert, command, address, optional dummy bytes, four data bytes, chip-select release. Returns one little-endian 32-bit word. When no fetch is active, CPU MMIO accesses pass through to the engine unchanged, so software keeps raw SPI access.

---
 rtl/spi_flash_sequencer_if.sv | 38 +++
 rtl/spi_flash_sequencer.sv | 139 +++++++++++++
 tb/tb_spi_flash_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_sequencer_if.sv
// Bus bundle for the SPI flash sequencer: fetch port, CPU MMIO port and the
// byte-wide SPI engine port, plus the busy flag.
interface spi_flash_sequencer_if;
    logic        fetch_valid;
    logic [23:0] fetch_addr;
    logic        fetch_ready;
    logic [31:0] fetch_rdata;

    logic        cpu_valid;
    logic        cpu_ctrl;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;

    logic        spi_valid;
    logic        spi_ctrl;
    logic [31:0] spi_wdata;
    logic [3:0]  spi_wstrb;
    logic [31:0] spi_rdata;
    logic        spi_ready;

    logic        busy;

    modport slave (
        input  fetch_valid, fetch_addr, cpu_valid, cpu_ctrl, cpu_wdata, cpu_wstrb,
               spi_rdata, spi_ready,
        output fetch_ready, fetch_rdata, cpu_rdata, cpu_ready,
               spi_valid, spi_ctrl, spi_wdata, spi_wstrb, busy
    );

    modport master (
        output fetch_valid, fetch_addr, cpu_valid, cpu_ctrl, cpu_wdata, cpu_wstrb,
               spi_rdata, spi_ready,
        input  fetch_ready, fetch_rdata, cpu_rdata, cpu_ready,
               spi_valid, spi_ctrl, spi_wdata, spi_wstrb, busy
    );
endinterface

// File: rtl/spi_flash_sequencer.sv
// Turns a 24-bit word fetch into a full SPI read transaction on the byte engine;
// when idle, CPU MMIO accesses pass straight through to the engine.
module spi_flash_sequencer #(
    parameter logic [7:0] READ_CMD    = 8'h03,
    parameter int         DUMMY_BYTES = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    spi_flash_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, PASS, CS_ON, TX, POLL, RX, CS_OFF, DONE} state_t;

    localparam logic [3:0] FIRST_DATA = 4'(4 + DUMMY_BYTES);
    localparam logic [3:0] LAST_IDX   = 4'(7 + DUMMY_BYTES);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fetch_ready_q, fetch_ready_d;
    logic        spi_valid_q, spi_valid_d;
    logic        spi_ctrl_q, spi_ctrl_d;
    logic [31:0] spi_wdata_q, spi_wdata_d;
    logic [3:0]  spi_wstrb_q, spi_wstrb_d;
    logic [1:0]  lane;
    logic        pass;

    function automatic logic [7:0] tx_byte(input logic [3:0] idx, input logic [23:0] addr);
        case (idx)
            4'd0:    return READ_CMD;
            4'd1:    return addr[23:16];
            4'd2:    return addr[15:8];
            4'd3:    return addr[7:0];
            default: return (idx >= FIRST_DATA) ? 8'hFF : 8'h00;
        endcase
    endfunction

    assign lane = 2'(idx_q - FIRST_DATA);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        spi_valid_d = spi_valid_q;
        spi_ctrl_d  = spi_ctrl_q;
        spi_wdata_d = spi_wdata_q;
        spi_wstrb_d = spi_wstrb_q;
        case (state_q)
            IDLE: begin
                if (bus.fetch_valid) begin
                    addr_d  = bus.fetch_addr;
                    idx_d   = '0;
                    state_d = CS_ON;
                end else if (bus.cpu_valid) begin
                    state_d = PASS;
                end
            end
            PASS: if (bus.spi_ready) state_d = IDLE;
            DONE: state_d = IDLE;
            default: begin
                // Each op state issues one engine access; its registers load as valid rises.
                if (!spi_valid_q) begin
                    spi_valid_d = 1'b1;
                    case (state_q)
                        CS_ON:   begin spi_ctrl_d = 1'b0; spi_wstrb_d = 4'h1; spi_wdata_d = 32'd1; end
                        CS_OFF:  begin spi_ctrl_d = 1'b0; spi_wstrb_d = 4'h1; spi_wdata_d = 32'd0; end
                        TX:      begin spi_ctrl_d = 1'b1; spi_wstrb_d = 4'h1;
                                       spi_wdata_d = {24'b0, tx_byte(idx_q, addr_q)}; end
                        POLL:    begin spi_ctrl_d = 1'b0; spi_wstrb_d = 4'h0; spi_wdata_d = 32'd0; end
                        default: begin spi_ctrl_d = 1'b1; spi_wstrb_d = 4'h0; spi_wdata_d = 32'd0; end
                    endcase
                end else if (bus.spi_ready) begin
                    spi_valid_d = 1'b0;
                    case (state_q)
                        CS_ON: state_d = TX;
                        TX:    state_d = POLL;
                        POLL: begin
                            if (!bus.spi_rdata[31]) begin
                                if (idx_q >= FIRST_DATA)    state_d = RX;
                                else if (idx_q == LAST_IDX) state_d = CS_OFF;
                                else begin
                                    state_d = TX;
                                    idx_d   = idx_q + 4'd1;
                                end
                            end
                        end
                        RX: begin
                            rdata_d[{lane, 3'b000} +: 8] = bus.spi_rdata[7:0];
                            if (idx_q == LAST_IDX) state_d = CS_OFF;
                            else begin
                                state_d = TX;
                                idx_d   = idx_q + 4'd1;
                            end
                        end
                        default: state_d = DONE;
                    endcase
                end
            end
        endcase
        fetch_ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            addr_q        <= '0;
            rdata_q       <= '0;
            fetch_ready_q <= 1'b0;
            spi_valid_q   <= 1'b0;
            spi_ctrl_q    <= 1'b0;
            spi_wdata_q   <= '0;
            spi_wstrb_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            addr_q        <= addr_d;
            rdata_q       <= rdata_d;
            fetch_ready_q <= fetch_ready_d;
            spi_valid_q   <= spi_valid_d;
            spi_ctrl_q    <= spi_ctrl_d;
            spi_wdata_q   <= spi_wdata_d;
            spi_wstrb_q   <= spi_wstrb_d;
        end
    end

    // Raw CPU access owns the engine only while in PASS.
    assign pass            = (state_q == PASS);
    assign bus.spi_valid   = pass ? bus.cpu_valid : spi_valid_q;
    assign bus.spi_ctrl    = pass ? bus.cpu_ctrl  : spi_ctrl_q;
    assign bus.spi_wdata   = pass ? bus.cpu_wdata : spi_wdata_q;
    assign bus.spi_wstrb   = pass ? bus.cpu_wstrb : spi_wstrb_q;
    assign bus.cpu_ready   = pass & bus.spi_ready;
    assign bus.cpu_rdata   = pass ? bus.spi_rdata : 32'd0;
    assign bus.fetch_ready = fetch_ready_q;
    assign bus.fetch_rdata = rdata_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Bench for spi_flash_sequencer: two instances (plain 03 read, and 0B read with
// one dummy byte) against a behavioural SPI engine + flash model.
module tb_spi_flash_sequencer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        fv[2];  logic [23:0] fa[2];
    logic        cv[2];  logic        cc[2]; logic [31:0] cw[2]; logic [3:0] cs4[2];
    logic        erdy[2]; logic [31:0] erd[2];
    logic        sv[2];  logic        sc[2]; logic [31:0] swd[2]; logic [3:0] sws[2];
    logic        fr[2];  logic [31:0] frd[2]; logic cr[2]; logic [31:0] crd[2]; logic bsy[2];

    spi_flash_sequencer_if bus0();
    spi_flash_sequencer_if bus1();

    assign bus0.fetch_valid = fv[0];  assign bus0.fetch_addr = fa[0];
    assign bus0.cpu_valid = cv[0];    assign bus0.cpu_ctrl = cc[0];
    assign bus0.cpu_wdata = cw[0];    assign bus0.cpu_wstrb = cs4[0];
    assign bus0.spi_ready = erdy[0];  assign bus0.spi_rdata = erd[0];
    assign sv[0] = bus0.spi_valid;    assign sc[0] = bus0.spi_ctrl;
    assign swd[0] = bus0.spi_wdata;   assign sws[0] = bus0.spi_wstrb;
    assign fr[0] = bus0.fetch_ready;  assign frd[0] = bus0.fetch_rdata;
    assign cr[0] = bus0.cpu_ready;    assign crd[0] = bus0.cpu_rdata;
    assign bsy[0] = bus0.busy;

    assign bus1.fetch_valid = fv[1];  assign bus1.fetch_addr = fa[1];
    assign bus1.cpu_valid = cv[1];    assign bus1.cpu_ctrl = cc[1];
    assign bus1.cpu_wdata = cw[1];    assign bus1.cpu_wstrb = cs4[1];
    assign bus1.spi_ready = erdy[1];  assign bus1.spi_rdata = erd[1];
    assign sv[1] = bus1.spi_valid;    assign sc[1] = bus1.spi_ctrl;
    assign swd[1] = bus1.spi_wdata;   assign sws[1] = bus1.spi_wstrb;
    assign fr[1] = bus1.fetch_ready;  assign frd[1] = bus1.fetch_rdata;
    assign cr[1] = bus1.cpu_ready;    assign crd[1] = bus1.cpu_rdata;
    assign bsy[1] = bus1.busy;

    spi_flash_sequencer #(.READ_CMD(8'h03), .DUMMY_BYTES(0)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0.slave));
    spi_flash_sequencer #(.READ_CMD(8'h0B), .DUMMY_BYTES(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1.slave));

    int errors = 0;
    int checks = 0;
    int busy_len = 2;
    int stab_err = 0;

    // Engine + flash model state; instance g uses g dummy bytes.
    logic        cs_st[2];
    int          bcnt[2], wcnt[2], pos[2];
    logic        pend[2];
    logic [36:0] held[2];
    logic [23:0] maddr[2];
    logic [7:0]  rxb[2];
    logic [7:0]  txlog[2][16];
    int          txn[2]    = '{0, 0};
    int          ncsoff[2] = '{0, 0};
    int          npoll[2]  = '{0, 0};

    function automatic logic [7:0] mem(input logic [23:0] a);
        return 8'hA0 + (a[7:0] - 8'h45) + (a[15:8] - 8'h23);
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {mem(a + 24'd3), mem(a + 24'd2), mem(a + 24'd1), mem(a)};
    endfunction

    always @(posedge clk or negedge resetn) begin
        logic [7:0] b;
        if (!resetn) begin
            for (int g = 0; g < 2; g++) begin
                erdy[g] <= 1'b0; erd[g] <= '0;
                cs_st[g] = 1'b0; bcnt[g] = 0; wcnt[g] = 0; pend[g] = 1'b0; pos[g] = 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (bcnt[g] > 0) bcnt[g]--;
                if (erdy[g]) erdy[g] <= 1'b0;
                else if (sv[g]) begin
                    if (!pend[g]) begin
                        pend[g] = 1'b1;
                        held[g] = {sc[g], swd[g], sws[g]};
                        wcnt[g] = int'($urandom_range(0, 3));
                    end else if ({sc[g], swd[g], sws[g]} != held[g]) stab_err++;
                    if (wcnt[g] == 0) begin
                        pend[g] = 1'b0;
                        erdy[g] <= 1'b1;
                        if (!sc[g] && sws[g][0]) begin
                            cs_st[g] = swd[g][0];
                            if (swd[g][0]) begin pos[g] = 0; txn[g] = 0; end
                            else ncsoff[g]++;
                            erd[g] <= '0;
                        end else if (sc[g] && sws[g][0]) begin
                            b = swd[g][7:0];
                            if (txn[g] < 16) txlog[g][txn[g]] = b;
                            txn[g]++;
                            if (pos[g] >= 1 && pos[g] <= 3) maddr[g] = {maddr[g][15:0], b};
                            rxb[g] = (pos[g] >= 4 + g) ? mem(maddr[g] + 24'(pos[g] - 4 - g)) : 8'hEF;
                            pos[g]++;
                            bcnt[g] = busy_len;
                            erd[g] <= '0;
                        end else if (!sc[g]) begin
                            npoll[g]++;
                            erd[g] <= {bcnt[g] != 0, 30'b0, cs_st[g]};
                        end else begin
                            erd[g] <= {24'b0, rxb[g]};
                        end
                    end else wcnt[g]--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input int g, input logic [23:0] a, input string tag, output logic [31:0] got);
        logic seen; int pulses; int hold_bad; int c0; int bad;
        logic [7:0] q[$];
        seen = 1'b0; pulses = 0; hold_bad = 0; bad = 0; got = '0; c0 = ncsoff[g];
        q.delete();
        q.push_back(g == 0 ? 8'h03 : 8'h0B);
        q.push_back(a[23:16]); q.push_back(a[15:8]); q.push_back(a[7:0]);
        for (int i = 0; i < g; i++) q.push_back(8'h00);
        for (int i = 0; i < 4; i++) q.push_back(8'hFF);
        @(posedge clk); #1; fv[g] = 1'b1; fa[g] = a;
        for (int t = 0; t < 20000 && !seen; t++) begin
            @(negedge clk);
            if (fr[g] === 1'b1) begin seen = 1'b1; got = frd[g]; end
        end
        chk({tag, "/ready"}, 32'(seen), 32'd1);
        @(posedge clk); #1; fv[g] = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (fr[g] !== 1'b0) pulses++;
            if (frd[g] !== got) hold_bad++;
        end
        chk({tag, "/extra_ready"}, 32'(pulses), 32'd0);
        chk({tag, "/hold"}, 32'(hold_bad), 32'd0);
        chk({tag, "/rdata"}, got, exp_word(a));
        chk({tag, "/busy_idle"}, 32'(bsy[g]), 32'd0);
        chk({tag, "/tx_count"}, 32'(txn[g]), 32'(q.size()));
        for (int i = 0; i < q.size() && i < 16; i++) if (txlog[g][i] !== q[i]) bad++;
        chk({tag, "/tx_bytes"}, 32'(bad), 32'd0);
        chk({tag, "/cs_off"}, 32'(ncsoff[g] - c0), 32'd1);
    endtask

    task automatic cpu_op(input int g, input logic ctrl, input logic [31:0] wd, input logic [3:0] ws,
                          input string tag, output logic [31:0] rd);
        logic seen; int mis;
        seen = 1'b0; mis = 0; rd = '0;
        @(posedge clk); #1; cv[g] = 1'b1; cc[g] = ctrl; cw[g] = wd; cs4[g] = ws;
        for (int t = 0; t < 500 && !seen; t++) begin
            @(negedge clk);
            if (bsy[g] && (sv[g] !== cv[g] || sc[g] !== cc[g] || swd[g] !== cw[g] || sws[g] !== cs4[g])) mis++;
            if (cr[g] === 1'b1) begin seen = 1'b1; rd = crd[g]; end
        end
        chk({tag, "/ready"}, 32'(seen), 32'd1);
        chk({tag, "/mirror"}, 32'(mis), 32'd0);
        @(posedge clk); #1; cv[g] = 1'b0;
        @(negedge clk);
        chk({tag, "/idle_rdata"}, crd[g], 32'd0);
    endtask

    initial begin
        logic [31:0] got, rd;
        logic [23:0] addr;
        logic found, dropf, dropc;
        int p0, frp, crp, tf, tc, gi;
        for (int g = 0; g < 2; g++) begin
            fv[g] = 1'b0; fa[g] = '0; cv[g] = 1'b0; cc[g] = 1'b0; cw[g] = '0; cs4[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst/spi_valid", 32'(sv[0]), 32'd0);
        chk("rst/busy", 32'(bsy[0]), 32'd0);
        chk("rst/fetch_ready", 32'(fr[0]), 32'd0);
        chk("rst/fetch_rdata", frd[0], 32'd0);
        chk("rst/spi_regs", {swd[0][27:0], sws[0]}, 32'd0);
        chk("rst/spi_ctrl", 32'(sc[0]), 32'd0);
        chk("rst/cpu_ready", 32'(cr[0]), 32'd0);
        resetn = 1'b1;

        do_fetch(0, 24'h012345, "plan_fetch", got);
        chk("plan_fetch/word", got, 32'hA3A2A1A0);
        do_fetch(1, 24'h012345, "dummy_fetch", got);
        do_fetch(1, 24'hFFFFFE, "dummy_wrap", got);

        for (int i = 0; i < 6; i++) begin
            busy_len = int'($urandom_range(0, 5));
            gi = int'($urandom_range(0, 1));
            addr = 24'($urandom());
            do_fetch(gi, addr, "rand_fetch", got);
        end

        busy_len = 2;
        cpu_op(0, 1'b0, 32'd1, 4'h1, "cpu_cs_on", rd);
        cpu_op(0, 1'b1, 32'h9F, 4'h1, "cpu_tx", rd);
        chk("cpu_tx/byte", {24'b0, txlog[0][0]}, 32'h9F);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cpu_op(0, 1'b0, 32'd0, 4'h0, "cpu_poll", rd);
            if (!rd[31]) found = 1'b1;
        end
        chk("cpu_poll/done", 32'(found), 32'd1);
        chk("cpu_poll/cs", 32'(rd[0]), 32'd1);
        cpu_op(0, 1'b1, 32'd0, 4'h0, "cpu_rx", rd);
        chk("cpu_rx/byte", {24'b0, rd[7:0]}, 32'hEF);
        cpu_op(0, 1'b0, 32'd0, 4'h1, "cpu_cs_off", rd);

        addr = 24'($urandom());
        @(posedge clk); #1;
        fv[0] = 1'b1; fa[0] = addr; cv[0] = 1'b1; cc[0] = 1'b0; cw[0] = '0; cs4[0] = '0;
        frp = 0; crp = 0; tf = -1; tc = -1; got = '0;
        for (int t = 0; t < 20000 && (fv[0] || cv[0]); t++) begin
            @(negedge clk);
            dropf = 1'b0; dropc = 1'b0;
            if (fr[0] === 1'b1) begin frp++; tf = t; got = frd[0]; dropf = 1'b1; end
            if (cr[0] === 1'b1) begin crp++; tc = t; dropc = 1'b1; end
            @(posedge clk); #1;
            if (dropf) fv[0] = 1'b0;
            if (dropc) cv[0] = 1'b0;
        end
        fv[0] = 1'b0; cv[0] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (fr[0] === 1'b1) frp++;
            if (cr[0] === 1'b1) crp++;
        end
        chk("both/fetch_pulses", 32'(frp), 32'd1);
        chk("both/cpu_pulses", 32'(crp), 32'd1);
        chk("both/fetch_first", 32'(tf >= 0 && tf < tc), 32'd1);
        chk("both/rdata", got, exp_word(addr));

        busy_len = 50;
        p0 = npoll[0];
        do_fetch(0, 24'($urandom()), "slow_fetch", got);
        chk("slow_fetch/polls", 32'(npoll[0] - p0 >= 16), 32'd1);
        busy_len = 3;

        @(posedge clk); #1; fv[0] = 1'b1; fa[0] = 24'($urandom());
        found = 1'b0;
        for (int t = 0; t < 5000 && !found; t++) begin
            @(negedge clk);
            if (txn[0] == 2 && sv[0] === 1'b1 && sc[0] === 1'b1 && sws[0] === 4'h1) found = 1'b1;
        end
        chk("mid_rst/third_tx", 32'(found), 32'd1);
        #2; resetn = 1'b0;
        #1;
        chk("mid_rst/spi_valid", 32'(sv[0]), 32'd0);
        chk("mid_rst/busy", 32'(bsy[0]), 32'd0);
        chk("mid_rst/fetch_rdata", frd[0], 32'd0);
        chk("mid_rst/spi_wdata", swd[0], 32'd0);
        fv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1; resetn = 1'b1;
        do_fetch(0, 24'($urandom()), "post_rst0", got);
        do_fetch(1, 24'($urandom()), "post_rst1", got);

        chk("op_stability", 32'(stab_err), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
